// File: rtl/niosii_pio_edge_capture.sv
// niosii_pio_edge_capture
//   Avalon-MM parallel input port with per-bit edge capture and interrupt.
//   in_port is synchronised, edges are detected per bit and latched into a
//   write-1-to-clear capture register, and irq is raised from either the
//   masked input level or the masked capture register.
//
// Ports
//   clk, reset_n   : clock, asynchronous active-low reset
//   address        : word address (0 data, 1 reserved, 2 irq mask, 3 edge capture)
//   chipselect     : access qualifier
//   write_n        : active-low write strobe
//   writedata      : write data
//   in_port        : asynchronous external inputs
//   readdata       : registered read data, one-cycle latency
//   irq            : interrupt request, active high

// Per-bit lane: synchroniser, delayed copy, edge detect and capture flop.
module niosii_pio_edge_lane #(
   parameter int SYNC_STAGES = 2,
   parameter int EDGE_TYPE   = 0
) (
   input  logic clk,
   input  logic reset_n,
   input  logic in_bit,
   input  logic det_en,
   input  logic clr,
   output logic data_in,
   output logic cap
);
   logic [SYNC_STAGES-1:0] sync_q;
   logic                   prev_in;
   logic                   edge_det;

   assign data_in = sync_q[SYNC_STAGES-1];

   always_comb begin
      edge_det = 1'b0;
      case (EDGE_TYPE)
         0:       edge_det =  data_in & ~prev_in;
         1:       edge_det = ~data_in &  prev_in;
         default: edge_det =  data_in ^  prev_in;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         sync_q  <= '0;
         prev_in <= 1'b0;
         cap     <= 1'b0;
      end else begin
         sync_q  <= {sync_q[SYNC_STAGES-2:0], in_bit};
         prev_in <= data_in;
         // OR-ing the set term last gives a coincident edge priority over clear.
         cap     <= (cap & ~clr) | (edge_det & det_en);
      end
   end
endmodule

module niosii_pio_edge_capture #(
   parameter int WIDTH       = 8,
   parameter int EDGE_TYPE   = 0,
   parameter int IRQ_MODE    = 1,
   parameter int SYNC_STAGES = 2
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic [1:0]       address,
   input  logic             chipselect,
   input  logic             write_n,
   input  logic [31:0]      writedata,
   input  logic [WIDTH-1:0] in_port,
   output logic [31:0]      readdata,
   output logic             irq
);
   localparam logic [2:0] PRIME_MAX = 3'(SYNC_STAGES + 1);

   logic [WIDTH-1:0] data_in;
   logic [WIDTH-1:0] edge_capture;
   logic [WIDTH-1:0] irq_mask;
   logic [WIDTH-1:0] clr_vec;
   logic [2:0]       prime_cnt;
   logic             det_en;
   logic             wr_en;
   logic [31:0]      rd_mux;
   logic             unused_wdata;

   assign wr_en   = chipselect & ~write_n;
   assign clr_vec = (wr_en && address == 2'd3) ? writedata[WIDTH-1:0] : '0;
   // Detection waits until the synchroniser and prev_in hold real samples,
   // so a level present at reset release is not mistaken for an edge.
   assign det_en  = (prime_cnt == PRIME_MAX);
   assign unused_wdata = ^writedata;

   for (genvar i = 0; i < WIDTH; i++) begin : g_lane
      niosii_pio_edge_lane #(
         .SYNC_STAGES (SYNC_STAGES),
         .EDGE_TYPE   (EDGE_TYPE)
      ) u_lane (
         .clk     (clk),
         .reset_n (reset_n),
         .in_bit  (in_port[i]),
         .det_en  (det_en),
         .clr     (clr_vec[i]),
         .data_in (data_in[i]),
         .cap     (edge_capture[i])
      );
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         prime_cnt <= '0;
         irq_mask  <= '0;
      end else begin
         if (!det_en)
            prime_cnt <= prime_cnt + 3'd1;
         if (wr_en && address == 2'd2)
            irq_mask <= writedata[WIDTH-1:0];
      end
   end

   always_comb begin
      rd_mux = '0;
      case (address)
         2'd0:    rd_mux[WIDTH-1:0] = data_in;
         2'd2:    rd_mux[WIDTH-1:0] = irq_mask;
         2'd3:    rd_mux[WIDTH-1:0] = edge_capture;
         default: rd_mux = '0;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)
         readdata <= '0;
      else
         readdata <= rd_mux;
   end

   // Combinational OR of registers only; no path from in_port or the bus.
   if (IRQ_MODE == 0) begin : g_irq_level
      assign irq = |(data_in & irq_mask);
   end else begin : g_irq_edge
      assign irq = |(edge_capture & irq_mask);
   end
endmodule

// File: doc/niosii_pio_edge_capture.md
NIOSII_PIO_EDGE_CAPTURE -- requirements
Module: niosii_pio_edge_capture

Interface
REQ-001 SHALL provide parameter WIDTH, default 8, input port width in bits; legal range 1..32.
REQ-002 SHALL provide parameter EDGE_TYPE, default 0, capture edge: 0 rising, 1 falling, 2 any.
REQ-003 SHALL provide parameter IRQ_MODE, default 1, interrupt source: 0 level (data), 1 edge (capture register).
REQ-004 SHALL provide parameter SYNC_STAGES, default 2, synchroniser depth on in_port; legal range 2..3.
REQ-005 SHALL use one clock, clk, with an asynchronous active-low reset, reset_n.
REQ-006 SHALL provide the following ports:
- clk  input  1  system clock, all state on rising edge.
- reset_n  input  1  asynchronous active-low reset.
- address  input  2  Avalon slave word address.
- chipselect  input  1  slave access qualifier.
- write_n  input  1  active-low write strobe, valid with chipselect.
- writedata  input  32  write data.
- in_port  input  WIDTH  asynchronous external inputs.
- readdata  output  32  registered read data.
- irq  output  1  interrupt request, active high.

Function
REQ-007 SHALL pass in_port through a SYNC_STAGES-deep flop chain; the final stage is data_in.
REQ-008 SHALL hold prev_in, a one-cycle-delayed copy of data_in.
REQ-009 SHALL detect edges per bit:
- rising = data_in & ~prev_in
- falling = ~data_in & prev_in
- any = XOR of data_in and prev_in
- selection by EDGE_TYPE.
REQ-010 SHALL implement a WIDTH-bit edge_capture register; a bit sets on a detected edge and holds until cleared.
REQ-011 SHALL clear edge_capture bit n on a write (chipselect=1, write_n=0) to address 3 with writedata[n]=1; bits with writedata[n]=0 are unchanged.
REQ-012 SHALL give set priority over clear when an edge and a clear hit the same bit in the same cycle; the bit remains 1.
REQ-013 SHALL implement a WIDTH-bit irq_mask register, written from writedata[WIDTH-1:0] on a write to address 2.
REQ-014 SHALL ignore writes to addresses 0 and 1.
REQ-015 SHALL drive irq from registered state only:
- IRQ_MODE=0: irq = OR(data_in & irq_mask).
- IRQ_MODE=1: irq = OR(edge_capture & irq_mask).
REQ-016 SHALL register readdata every clock, with one-cycle read latency and no wait states:
- address 0: data_in
- address 1: 0
- address 2: irq_mask
- address 3: edge_capture
- bits 31:WIDTH zero-filled.
REQ-017 SHALL suppress edge detection while a reset-prime counter runs. The counter starts at 0 on reset and counts to SYNC_STAGES+1, then saturates. Detection is enabled only at saturation, so a level already present at reset release is never captured as an edge.
REQ-018 SHALL meet the following latencies:
- in_port change to data_in: SYNC_STAGES clocks.
- in_port change to edge_capture set and IRQ_MODE=1 irq assertion: SYNC_STAGES+1 clocks.
- Register to readdata: +1 clock.
REQ-019 SHALL capture an edge lasting exactly one synchronised cycle; pulses shorter than one clk period are not guaranteed.
REQ-020 SHALL make irq_mask writes take effect on irq in the cycle after the write.

Reset
REQ-021 SHALL, while reset_n=0, asynchronously clear all of the following: synchroniser flops, prev_in, edge_capture, irq_mask, prime counter, readdata.
REQ-022 SHALL drive irq=0 and readdata=0 during reset and in the first cycle after release.
REQ-023 SHALL, on reset asserted mid-operation, discard pending captures and mask state immediately; no capture survives reset.

Verification
REQ-024 Edge capture and irq, WIDTH=8, EDGE_TYPE=0, IRQ_MODE=1, SYNC_STAGES=2:
- Stimulus: write mask 0x01, then drive in_port 0x00 -> 0x01.
- Response: irq=1 exactly 3 clocks after the change; read addr 3 returns 0x00000001.
REQ-025 Write-1-to-clear:
- Stimulus: edge_capture=0x05; write 0x04 to addr 3.
- Response: addr 3 reads 0x01; irq stays 1 if mask bit 0 is set.
REQ-026 Simultaneous set/clear:
- Stimulus: write 0x01 to addr 3 in the same cycle a rising edge on bit 0 is detected.
- Response: addr 3 reads 0x01.
REQ-027 Reset with input high:
- Stimulus: hold in_port=0xFF through reset release; wait 10 clocks.
- Response: addr 3 reads 0x00; addr 0 reads 0x000000FF; irq=0.
REQ-028 Level mode, IRQ_MODE=0, EDGE_TYPE=2:
- Stimulus: mask 0x80, in_port=0x80.
- Response: irq=1 after 2 clocks; drop in_port to 0x00 -> irq=0 after 2 clocks; bit 7 captured on both edges.
REQ-029 Width fill:
- Stimulus: WIDTH=3, in_port=0x7.
- Response: addr 0 reads 0x00000007; unused bits 0.
